recon_frame_writer: RTL and testbench
=====================================

Name: recon_frame_writer

Overview:
- Write-side counterpart of the intra-prediction macroblock fetch path.
- Accepts one reconstructed macroblock per handshake and writes it row by row into an internal reconstructed-frame store.
- Serves top-row and left-column neighbour pixels from that store, so intra prediction uses reconstructed pixels rather than source pixels.
- Sits between the reconstruction adder (upstream) and the intra predictor (neighbour consumer).

Parameters:
- LENGTH, 1280, frame width in pixels; also the row stride of the frame store.
- WIDTH, 720, frame height in lines.
- MB_SIZE_L, 16, lines per macroblock.
- MB_SIZE_W, 16, pixels per macroblock line.
- BORDER_VAL, 128, neighbour value returned outside the frame.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  macroblock offered.
- in_ready  out  1  block can accept a macroblock.
- in_mbnumber  in  13  raster index of the offered macroblock.
- mb_in  in  8 x MB_SIZE_L*MB_SIZE_W  pixels; index = line*MB_SIZE_W + col.
- wr_done  out  1  one-cycle pulse after the last line is written.
- oob_err  out  1  sticky flag: an out-of-range mbnumber was accepted.
- nb_req  in  1  neighbour read request.
- nb_mbnumber  in  13  macroblock whose neighbours are requested.
- nb_valid  out  1  neighbour outputs valid; 1 cycle after nb_req.
- toppixels  out  8 x MB_SIZE_W  line above the macroblock.
- leftpixels  out  8 x MB_SIZE_L  column left of the macroblock.

Behaviour:
- Geometry constants:
  - MBS_PER_ROW = LENGTH/MB_SIZE_W
  - MBS_PER_COL = WIDTH/MB_SIZE_L
  - NUM_MB = MBS_PER_ROW*MBS_PER_COL (3600 at defaults)
- Address mapping:
  - mb_x = mbnumber % MBS_PER_ROW; mb_y = mbnumber / MBS_PER_ROW.
  - px = mb_x*MB_SIZE_W; py = mb_y*MB_SIZE_L.
  - Pixel address = (py+line)*LENGTH + px + col.
  - All address math in 32-bit unsigned; no truncation.
- Frame store:
  - LENGTH*WIDTH bytes.
  - Initialised to BORDER_VAL by an initial block; not cleared by reset.
- FSM: IDLE, WRITE, DONE.
  - IDLE: in_ready=1. On in_valid, capture mb_in and in_mbnumber into a holding buffer, clear line counter, go to WRITE.
  - WRITE: in_ready=0. Each cycle, write MB_SIZE_W pixels of line[cnt]. After cnt==MB_SIZE_L-1, go to DONE.
  - DONE: wr_done=1 for exactly one cycle, in_ready=0, then IDLE.
- Throughput: MB_SIZE_L+2 cycles per macroblock (18 at defaults), accept cycle included.
- mb_in is ignored except in the accept cycle; later changes have no effect.
- Out-of-range write (mbnumber >= NUM_MB):
  - Accepted and sequenced normally, including wr_done.
  - All writes suppressed.
  - oob_err set; it clears only on reset.
- Neighbour port:
  - Independent of the FSM; nb_req is honoured in any state.
  - Registered read; nb_valid asserts the cycle after nb_req, outputs held until the next nb_req.
  - toppixels[c] = BORDER_VAL if py==0, else store[(py-1)*LENGTH + px + c].
  - leftpixels[l] = BORDER_VAL if px==0, else store[(py+l)*LENGTH + px - 1].
  - Out-of-range nb_mbnumber: all outputs BORDER_VAL, nb_valid still asserts.
- Read/write collision in the same cycle: read returns pre-write data (read-before-write).
- Reset values:
  - State=IDLE, line counter=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - wr_done=0, oob_err=0, nb_valid=0.
  - toppixels and leftpixels all BORDER_VAL.
- Reset during WRITE: aborts immediately, no wr_done. Lines already written persist; remaining lines are not written.

Optional Feature:
- Macro RECON_TOPLEFT_EN.
- Defined: adds output topleft (8 bits), valid with nb_valid.
  - Value = BORDER_VAL if px==0 or py==0, else store[(py-1)*LENGTH + px - 1].
  - Reset value BORDER_VAL.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package intra_pkg holds:
  - geometry localparams MBS_PER_ROW, MBS_PER_COL, NUM_MB;
  - BORDER_VAL;
  - FSM state enum typedef;
  - pixel typedef (logic [7:0]);
  - mb-to-pixel-origin function (mbnumber -> px, py).
- One sub-module, mb_addr_gen: combinational mapping of mbnumber and line to the base address plus border flags. Instanced twice, once for the write path and once for the read path.

Test Plan:
- Write with in_mbnumber=0, mb_in[i]=i[7:0] -> wr_done exactly 17 cycles after accept. Then nb_req for mb 1 -> leftpixels[l]=l*16+15; toppixels all 128.
- Write mb 0, then nb_req for mb 80 -> toppixels[c]=240+c; leftpixels all 128.
- Fresh store, nb_req for mb 81 -> toppixels and leftpixels all 128 (initial fill). With RECON_TOPLEFT_EN, topleft=128; after writing mb 0 with mb_in[i]=i[7:0], topleft=8'hFF.
- in_mbnumber=3600 -> oob_err=1, wr_done pulses, store unchanged (neighbour read of mb 1 still returns 128).
- Assert reset at WRITE line 5 -> no wr_done; in_ready=1 the cycle after reset deasserts. Lines 0-4 of the target mb hold new data, lines 5-15 hold old data.
- In_valid held high continuously -> one accept per 18 cycles; in_ready low during WRITE and DONE. An nb_req issued mid-write still returns nb_valid the next cycle.

Source files
------------

// File: rtl/intra_pkg.sv
// rtl/intra_pkg.sv - shared geometry, pixel/state types and macroblock origin mapping
// Optional RECON_TOPLEFT_EN feature lives in recon_frame_writer.
package intra_pkg;

   localparam int DEF_LENGTH    = 1280;
   localparam int DEF_WIDTH     = 720;
   localparam int DEF_MB_SIZE_L = 16;
   localparam int DEF_MB_SIZE_W = 16;

   localparam int MBS_PER_ROW = DEF_LENGTH / DEF_MB_SIZE_W;
   localparam int MBS_PER_COL = DEF_WIDTH / DEF_MB_SIZE_L;
   localparam int NUM_MB      = MBS_PER_ROW * MBS_PER_COL;

   typedef logic [7:0] pixel_t;

   localparam pixel_t BORDER_VAL = 8'd128;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_DONE
   } wr_state_t;

   typedef struct packed {
      logic [31:0] px;
      logic [31:0] py;
   } mb_origin_t;

   function automatic mb_origin_t mb_origin(input logic [31:0] mbn,
                                            input logic [31:0] per_row,
                                            input logic [31:0] mb_w,
                                            input logic [31:0] mb_l);
      mb_origin_t o;
      o.px = (mbn % per_row) * mb_w;
      o.py = (mbn / per_row) * mb_l;
      return o;
   endfunction

endpackage

// File: rtl/mb_addr_gen.sv
// rtl/mb_addr_gen.sv - mbnumber/line to frame-store line base address plus border flags
// Purely combinational; shared by the write and neighbour-read paths.
module mb_addr_gen
   import intra_pkg::*;
#(
   parameter int LENGTH    = DEF_LENGTH,
   parameter int MB_SIZE_W = DEF_MB_SIZE_W,
   parameter int MB_SIZE_L = DEF_MB_SIZE_L,
   parameter int ROW_MBS   = MBS_PER_ROW,
   parameter int TOTAL_MBS = NUM_MB,
   parameter int LW        = $clog2(DEF_MB_SIZE_L)
) (
   input  logic [12:0]   mbnumber,
   input  logic [LW-1:0] line,
   output logic [31:0]   base,
   output logic          top_edge,
   output logic          left_edge,
   output logic          oob
);

   localparam logic [31:0] LEN_U = 32'(LENGTH);
   localparam logic [31:0] MBW_U = 32'(MB_SIZE_W);
   localparam logic [31:0] MBL_U = 32'(MB_SIZE_L);
   localparam logic [31:0] ROW_U = 32'(ROW_MBS);
   localparam logic [31:0] TOT_U = 32'(TOTAL_MBS);

   mb_origin_t org;

   always_comb begin
      org       = mb_origin({19'd0, mbnumber}, ROW_U, MBW_U, MBL_U);
      base      = (org.py + 32'(line)) * LEN_U + org.px;
      top_edge  = (org.py == 32'd0);
      left_edge = (org.px == 32'd0);
      oob       = ({19'd0, mbnumber} >= TOT_U);
   end

endmodule

// File: rtl/recon_frame_writer.sv
// rtl/recon_frame_writer.sv - writes reconstructed macroblocks into a frame store and serves intra neighbours
// Define RECON_TOPLEFT_EN to add the registered topleft neighbour output.
module recon_frame_writer
   import intra_pkg::*;
#(
   parameter int         LENGTH     = DEF_LENGTH,
   parameter int         WIDTH      = DEF_WIDTH,
   parameter int         MB_SIZE_L  = DEF_MB_SIZE_L,
   parameter int         MB_SIZE_W  = DEF_MB_SIZE_W,
   parameter logic [7:0] BORDER_VAL = intra_pkg::BORDER_VAL
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [12:0] in_mbnumber,
   input  logic [7:0]  mb_in [MB_SIZE_L*MB_SIZE_W],
   output logic        wr_done,
   output logic        oob_err,
   input  logic        nb_req,
   input  logic [12:0] nb_mbnumber,
   output logic        nb_valid,
   output logic [7:0]  toppixels [MB_SIZE_W],
   output logic [7:0]  leftpixels [MB_SIZE_L]
`ifdef RECON_TOPLEFT_EN
   ,output logic [7:0] topleft
`endif
);

   localparam int ROW_MBS   = LENGTH / MB_SIZE_W;
   localparam int COL_MBS   = WIDTH / MB_SIZE_L;
   localparam int TOTAL_MBS = ROW_MBS * COL_MBS;
   localparam int NPIX      = MB_SIZE_L * MB_SIZE_W;
   localparam int FRAME_SZ  = LENGTH * WIDTH;
   localparam int AW        = $clog2(FRAME_SZ);
   localparam int LW        = $clog2(MB_SIZE_L);
   localparam int CW        = $clog2(MB_SIZE_W);
   localparam int PW        = $clog2(NPIX);

   localparam logic [31:0] LEN_U = 32'(LENGTH);
   localparam logic [31:0] TOT_U = 32'(TOTAL_MBS);

   pixel_t store [FRAME_SZ];

   // Power-up fill only; reset deliberately leaves the store alone.
   initial begin
      for (int i = 0; i < FRAME_SZ; i++) store[AW'(i)] = BORDER_VAL;
   end

   wr_state_t     state_q, state_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic [12:0]   mbn_q, mbn_d;
   pixel_t        hold_q [NPIX];
   pixel_t        hold_d [NPIX];
   logic          in_ready_q, in_ready_d;
   logic          wr_done_q, wr_done_d;
   logic          oob_q, oob_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mbn_d   = mbn_q;
      hold_d  = hold_q;
      oob_d   = oob_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               hold_d  = mb_in;
               mbn_d   = in_mbnumber;
               cnt_d   = '0;
               state_d = ST_WRITE;
               if ({19'd0, in_mbnumber} >= TOT_U) oob_d = 1'b1;
            end
         end
         ST_WRITE: begin
            cnt_d = cnt_q + LW'(1);
            if (cnt_q == LW'(MB_SIZE_L - 1)) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      in_ready_d = (state_d == ST_IDLE);
      wr_done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         in_ready_q <= 1'b1;
         wr_done_q  <= 1'b0;
         oob_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         in_ready_q <= in_ready_d;
         wr_done_q  <= wr_done_d;
         oob_q      <= oob_d;
      end
   end

   always_ff @(posedge clk) begin
      mbn_q  <= mbn_d;
      hold_q <= hold_d;
   end

   logic [31:0] wr_base;
   logic        wr_oob;
   logic        unused_wr_top;
   logic        unused_wr_left;
   logic        wr_en;

   mb_addr_gen #(
      .LENGTH(LENGTH), .MB_SIZE_W(MB_SIZE_W), .MB_SIZE_L(MB_SIZE_L),
      .ROW_MBS(ROW_MBS), .TOTAL_MBS(TOTAL_MBS), .LW(LW)
   ) u_wr_addr (
      .mbnumber (mbn_q),
      .line     (cnt_q),
      .base     (wr_base),
      .top_edge (unused_wr_top),
      .left_edge(unused_wr_left),
      .oob      (wr_oob)
   );

   // A reset landing mid-write must not commit the line in flight.
   assign wr_en = (state_q == ST_WRITE) && !wr_oob && !reset;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int c = 0; c < MB_SIZE_W; c++) begin
            store[AW'(wr_base + 32'(c))] <=
               hold_q[PW'(32'(cnt_q) * 32'(MB_SIZE_W) + 32'(c))];
         end
      end
   end

   logic [31:0] rd_base;
   logic        rd_top, rd_left, rd_oob;
   pixel_t      top_q [MB_SIZE_W];
   pixel_t      top_d [MB_SIZE_W];
   pixel_t      left_q [MB_SIZE_L];
   pixel_t      left_d [MB_SIZE_L];
   logic        nb_valid_q;

   mb_addr_gen #(
      .LENGTH(LENGTH), .MB_SIZE_W(MB_SIZE_W), .MB_SIZE_L(MB_SIZE_L),
      .ROW_MBS(ROW_MBS), .TOTAL_MBS(TOTAL_MBS), .LW(LW)
   ) u_rd_addr (
      .mbnumber (nb_mbnumber),
      .line     ('0),
      .base     (rd_base),
      .top_edge (rd_top),
      .left_edge(rd_left),
      .oob      (rd_oob)
   );

   // Reads sample the store before this edge's write lands (read-before-write).
   always_comb begin
      top_d  = top_q;
      left_d = left_q;
      if (nb_req) begin
         for (int c = 0; c < MB_SIZE_W; c++) begin
            top_d[CW'(c)] = (rd_oob || rd_top) ? BORDER_VAL
                          : store[AW'(rd_base - LEN_U + 32'(c))];
         end
         for (int l = 0; l < MB_SIZE_L; l++) begin
            left_d[LW'(l)] = (rd_oob || rd_left) ? BORDER_VAL
                           : store[AW'(rd_base + 32'(l) * LEN_U - 32'd1)];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         nb_valid_q <= 1'b0;
         for (int c = 0; c < MB_SIZE_W; c++) top_q[CW'(c)] <= BORDER_VAL;
         for (int l = 0; l < MB_SIZE_L; l++) left_q[LW'(l)] <= BORDER_VAL;
      end else begin
         nb_valid_q <= nb_req;
         top_q      <= top_d;
         left_q     <= left_d;
      end
   end

`ifdef RECON_TOPLEFT_EN
   pixel_t tl_q, tl_d;

   always_comb begin
      tl_d = tl_q;
      if (nb_req) begin
         tl_d = (rd_oob || rd_top || rd_left) ? BORDER_VAL
              : store[AW'(rd_base - LEN_U - 32'd1)];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) tl_q <= BORDER_VAL;
      else       tl_q <= tl_d;
   end

   assign topleft = tl_q;
`endif

   assign in_ready   = in_ready_q;
   assign wr_done    = wr_done_q;
   assign oob_err    = oob_q;
   assign nb_valid   = nb_valid_q;
   assign toppixels  = top_q;
   assign leftpixels = left_q;

endmodule

// File: tb/tb_recon_frame_writer.sv
// tb/tb_recon_frame_writer.sv - directed table-driven bench for recon_frame_writer
module tb_recon_frame_writer;

   localparam int MBL  = 16;
   localparam int MBW  = 16;
   localparam int NPIX = MBL * MBW;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [12:0] in_mbnumber;
   logic [7:0]  mb_in [NPIX];
   logic        wr_done;
   logic        oob_err;
   logic        nb_req;
   logic [12:0] nb_mbnumber;
   logic        nb_valid;
   logic [7:0]  toppixels [MBW];
   logic [7:0]  leftpixels [MBL];
`ifdef RECON_TOPLEFT_EN
   logic [7:0]  topleft;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [12:0] mb;
      logic [7:0]  t_base;
      logic [7:0]  t_step;
      logic [7:0]  l_base;
      logic [7:0]  l_step;
      logic [7:0]  tl;
   } nb_vec_t;

   nb_vec_t vecs [6];

   recon_frame_writer dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_mbnumber(in_mbnumber),
      .mb_in      (mb_in),
      .wr_done    (wr_done),
      .oob_err    (oob_err),
      .nb_req     (nb_req),
      .nb_mbnumber(nb_mbnumber),
      .nb_valid   (nb_valid),
      .toppixels  (toppixels),
      .leftpixels (leftpixels)
`ifdef RECON_TOPLEFT_EN
      ,.topleft   (topleft)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_ramp(input string name, input logic is_top,
                             input logic [7:0] base, input logic [7:0] stp);
      int bad;
      logic [7:0] exp_v, act_v;
      bad = 0;
      for (int i = 15; i >= 0; i--) begin
         exp_v = base + 8'(i) * stp;
         act_v = is_top ? toppixels[i] : leftpixels[i];
         if (act_v !== exp_v) bad = i;
      end
      exp_v = base + 8'(bad) * stp;
      act_v = is_top ? toppixels[bad] : leftpixels[bad];
      check($sformatf("%s[%0d]", name, bad), 32'(act_v), 32'(exp_v));
   endtask

   task automatic check_nb(input string name, input logic [12:0] mb,
                           input logic [7:0] t_base, input logic [7:0] t_step,
                           input logic [7:0] l_base, input logic [7:0] l_step,
                           input logic [7:0] tl);
      nb_req      = 1'b1;
      nb_mbnumber = mb;
      tick();
      nb_req = 1'b0;
      check({name, ".nb_valid"}, 32'(nb_valid), 32'd1);
      check_ramp({name, ".top"}, 1'b1, t_base, t_step);
      check_ramp({name, ".left"}, 1'b0, l_base, l_step);
`ifdef RECON_TOPLEFT_EN
      check({name, ".topleft"}, 32'(topleft), 32'(tl));
`else
      if (tl === 8'hxx) $display("note: unknown topleft expectation");
`endif
   endtask

   task automatic write_mb(input string name, input logic [12:0] mb);
      int lat;
      int ready_bad;
      in_mbnumber = mb;
      in_valid    = 1'b1;
      lat         = 0;
      ready_bad   = 0;
      do begin
         tick();
         lat++;
         if (lat == 1) in_valid = 1'b0;
         if (in_ready) ready_bad++;
      end while (!wr_done && lat < 40);
      check({name, ".wr_done_latency"}, 32'(lat), 32'd17);
      check({name, ".ready_low_while_busy"}, 32'(ready_bad), 32'd0);
      tick();
      check({name, ".wr_done_one_cycle"}, 32'(wr_done), 32'd0);
      check({name, ".ready_after_done"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int bad;
      int pattern_bad;
      logic [7:0] exp_v;

      reset       = 1'b1;
      in_valid    = 1'b0;
      in_mbnumber = '0;
      nb_req      = 1'b0;
      nb_mbnumber = '0;
      for (int i = 0; i < NPIX; i++) mb_in[i] = 8'd0;

      vecs[0] = '{13'd1,    8'd128, 8'd0, 8'd15,  8'd16, 8'd128};
      vecs[1] = '{13'd81,   8'd128, 8'd0, 8'd128, 8'd0,  8'd255};
      vecs[2] = '{13'd0,    8'd128, 8'd0, 8'd128, 8'd0,  8'd128};
      vecs[3] = '{13'd3600, 8'd128, 8'd0, 8'd128, 8'd0,  8'd128};
      vecs[4] = '{13'd79,   8'd128, 8'd0, 8'd128, 8'd0,  8'd128};
      vecs[5] = '{13'd80,   8'd240, 8'd1, 8'd128, 8'd0,  8'd128};

      // Reset state
      repeat (3) tick();
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check("rst.wr_done", 32'(wr_done), 32'd0);
      check("rst.oob_err", 32'(oob_err), 32'd0);
      check("rst.nb_valid", 32'(nb_valid), 32'd0);
      check_ramp("rst.top", 1'b1, 8'd128, 8'd0);
      check_ramp("rst.left", 1'b0, 8'd128, 8'd0);
`ifdef RECON_TOPLEFT_EN
      check("rst.topleft", 32'(topleft), 32'd128);
`endif
      reset = 1'b0;
      tick();
      check("post_rst.in_ready", 32'(in_ready), 32'd1);

      check_nb("fresh81", 13'd81, 8'd128, 8'd0, 8'd128, 8'd0, 8'd128);

      // Out-of-range write: sequenced normally, no store effect, sticky flag
      for (int i = 0; i < NPIX; i++) mb_in[i] = 8'h55;
      write_mb("oob", 13'd3600);
      check("oob.oob_err", 32'(oob_err), 32'd1);
      check_nb("oob_mb1", 13'd1, 8'd128, 8'd0, 8'd128, 8'd0, 8'd128);

      for (int i = 0; i < NPIX; i++) mb_in[i] = 8'(i);
      write_mb("mb0", 13'd0);
      check("mb0.oob_sticky", 32'(oob_err), 32'd1);

      for (int v = 0; v < 6; v++) begin
         check_nb($sformatf("vec%0d_mb%0d", v, vecs[v].mb), vecs[v].mb,
                  vecs[v].t_base, vecs[v].t_step, vecs[v].l_base, vecs[v].l_step, vecs[v].tl);
      end
      tick();
      check("hold.nb_valid_drop", 32'(nb_valid), 32'd0);
      check("hold.top5", 32'(toppixels[5]), 32'd245);

      // Back-to-back stream with in_valid held high
      for (int i = 0; i < NPIX; i++) mb_in[i] = 8'(i + 1);
      in_mbnumber = 13'd2;
      in_valid    = 1'b1;
      nb_req      = 1'b1;
      nb_mbnumber = 13'd3;
      pattern_bad = 0;
      for (int k = 1; k <= 54; k++) begin
         tick();
         if (k == 1) begin
            nb_req = 1'b0;
            check("rbw.nb_valid", 32'(nb_valid), 32'd1);
            check_ramp("rbw.left", 1'b0, 8'd128, 8'd0);
         end
         if (k == 3) begin
            for (int i = 0; i < NPIX; i++) mb_in[i] = 8'd0;
            in_mbnumber = 13'd4;
         end
         if (k == 5) begin
            nb_req      = 1'b1;
            nb_mbnumber = 13'd1;
         end
         if (k == 6) begin
            nb_req = 1'b0;
            check("midwrite.nb_valid", 32'(nb_valid), 32'd1);
            check_ramp("midwrite.left", 1'b0, 8'd15, 8'd16);
         end
         if (in_ready !== ((k % 18) == 0)) pattern_bad++;
         if (wr_done !== ((k % 18) == 17)) pattern_bad++;
      end
      in_valid = 1'b0;
      check("stream.ready_done_pattern", 32'(pattern_bad), 32'd0);
      tick();

      check_nb("stream_mb3", 13'd3, 8'd128, 8'd0, 8'd16, 8'd16, 8'd128);
      check_nb("stream_mb5", 13'd5, 8'd128, 8'd0, 8'd0, 8'd0, 8'd128);
      check_nb("stream_mb82", 13'd82, 8'd241, 8'd1, 8'd128, 8'd0, 8'd128);

      // Reset landing on the edge that would write line 5 of mb 80
      for (int i = 0; i < NPIX; i++) mb_in[i] = 8'h33;
      in_mbnumber = 13'd80;
      in_valid    = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) in_valid = 1'b0;
      end
      check("rstwr.busy_before", 32'(in_ready), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstwr.oob_cleared", 32'(oob_err), 32'd0);
      tick();
      check("rstwr.ready_after", 32'(in_ready), 32'd1);
      pattern_bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (wr_done !== 1'b0 || in_ready !== 1'b1) pattern_bad++;
         tick();
      end
      check("rstwr.no_wr_done", 32'(pattern_bad), 32'd0);

      nb_req      = 1'b1;
      nb_mbnumber = 13'd81;
      tick();
      nb_req = 1'b0;
      check("rstwr.nb_valid", 32'(nb_valid), 32'd1);
      check_ramp("rstwr.top", 1'b1, 8'd128, 8'd0);
      bad = 0;
      for (int l = 15; l >= 0; l--) begin
         exp_v = (l < 5) ? 8'h33 : 8'd128;
         if (leftpixels[l] !== exp_v) bad = l;
      end
      exp_v = (bad < 5) ? 8'h33 : 8'd128;
      check($sformatf("rstwr.left[%0d]", bad), 32'(leftpixels[bad]), 32'(exp_v));
`ifdef RECON_TOPLEFT_EN
      check("rstwr.topleft", 32'(topleft), 32'd255);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
